// File: rtl/nes_pkg.sv
// Shared definitions for the NES joypad poller: button bit positions and FSM states.
package nes_pkg;

  // Bit positions inside the button byte, also the order bits leave the 4021.
  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_idx_t;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SAMPLE,
    ST_SHIFT_LO,
    ST_CHECK
  } poll_state_t;

endpackage

// File: rtl/nes_joypad_poller_if.sv
// Pad pins and NES-core joypad signals bundled for the poller.
interface nes_joypad_poller_if;
  logic       enable;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       buttons_valid;
  logic       nes_strobe;
  logic       nes_clock;
  logic       nes_data;

  // Environment side: drives the pad data, enable and the NES read signals.
  modport master (
    output enable, pad_data, nes_strobe, nes_clock,
    input  pad_latch, pad_clk, buttons, buttons_valid, nes_data
  );

  // Poller side.
  modport slave (
    input  enable, pad_data, nes_strobe, nes_clock,
    output pad_latch, pad_clk, buttons, buttons_valid, nes_data
  );
endinterface

// File: rtl/nes_joypad_shifter.sv
// Emulated 4021 serving the NES core from the filtered button snapshot.
module nes_joypad_shifter (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_buttons,
  input  logic       i_strobe,
  input  logic       i_nes_clock,
  output logic       o_data
);
  import nes_pkg::*;

  logic [7:0] r_sr;
  logic       r_clk_prev;
  logic       w_fall;

  // Falling edge of the NES read clock: last sample high, current sample low.
  assign w_fall = r_clk_prev & ~i_nes_clock;

  // Strobe reloads every clock and wins over a coincident shift; ones fill in from the top.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sr       <= 8'h00;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_prev <= i_nes_clock;
      if (i_strobe) begin
        r_sr <= i_buttons;
      end else if (w_fall) begin
        r_sr <= {1'b1, r_sr[7:1]};
      end
    end
  end

  assign o_data = r_sr[BTN_A];

endmodule

// File: rtl/nes_joypad_poller.sv
// Periodic NES pad scanner with two-scan agreement filter and 4021-style NES port.
module nes_joypad_poller #(
  parameter int CLK_DIV     = 128,
  parameter int POLL_PERIOD = 357954
) (
  input  logic                i_clock,
  input  logic                i_reset,
  nes_joypad_poller_if.slave  bus
);
  import nes_pkg::*;

  localparam int POLL_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

  poll_state_t       r_state;
  logic [POLL_W-1:0] r_poll_cnt;
  logic [DIV_W-1:0]  r_phase_cnt;
  logic [2:0]        r_idx;
  logic              r_pad_latch;
  logic              r_pad_clk;
  logic [7:0]        r_scan;
  logic [7:0]        r_prev;
  logic [7:0]        r_buttons;
  logic              r_buttons_valid;
  logic [1:0]        r_pad_sync;

  logic w_poll_wrap;
  logic w_phase_last;
  logic w_pad_bit;
  logic w_nes_data;

  assign w_poll_wrap  = (r_poll_cnt == POLL_LAST);
  assign w_phase_last = (r_phase_cnt == DIV_LAST);
  // Pad line is asynchronous to us; it only matters at the end of a long phase.
  assign w_pad_bit    = ~r_pad_sync[1];

  // Two-flop synchroniser on the pad data pin; idle (released) level is high.
  always_ff @(posedge i_clock) begin
    if (i_reset) r_pad_sync <= 2'b11;
    else         r_pad_sync <= {r_pad_sync[0], bus.pad_data};
  end

  // Free-running poll timer, 0..POLL_PERIOD-1.
  always_ff @(posedge i_clock) begin
    if (i_reset)          r_poll_cnt <= '0;
    else if (w_poll_wrap) r_poll_cnt <= '0;
    else                  r_poll_cnt <= r_poll_cnt + POLL_W'(1);
  end

  // Scan sequencer: latch, 8 sample phases with 7 low phases between, then filter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state         <= ST_IDLE;
      r_phase_cnt     <= '0;
      r_idx           <= BTN_A;
      r_pad_latch     <= 1'b0;
      r_pad_clk       <= 1'b1;
      r_scan          <= 8'h00;
      r_prev          <= 8'h00;
      r_buttons       <= 8'h00;
      r_buttons_valid <= 1'b0;
    end else begin
      r_buttons_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_poll_wrap && bus.enable) begin
            r_state     <= ST_LATCH;
            r_phase_cnt <= '0;
            r_pad_latch <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (w_phase_last) begin
            r_state     <= ST_SAMPLE;
            r_phase_cnt <= '0;
            r_idx       <= BTN_A;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + DIV_W'(1);
          end
        end
        ST_SAMPLE: begin
          if (w_phase_last) begin
            r_scan[r_idx] <= w_pad_bit;
            r_phase_cnt   <= '0;
            if (r_idx == BTN_RIGHT) begin
              r_state <= ST_CHECK;
            end else begin
              r_state   <= ST_SHIFT_LO;
              r_pad_clk <= 1'b0;
            end
          end else begin
            r_phase_cnt <= r_phase_cnt + DIV_W'(1);
          end
        end
        ST_SHIFT_LO: begin
          if (w_phase_last) begin
            r_state     <= ST_SAMPLE;
            r_phase_cnt <= '0;
            r_idx       <= r_idx + 3'd1;
            r_pad_clk   <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + DIV_W'(1);
          end
        end
        ST_CHECK: begin
          // Accept a new value only when two consecutive scans agree.
          if ((r_scan == r_prev) && (r_scan != r_buttons)) begin
            r_buttons       <= r_scan;
            r_buttons_valid <= 1'b1;
          end
          r_prev  <= r_scan;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  nes_joypad_shifter u_shifter (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_buttons   (r_buttons),
    .i_strobe    (bus.nes_strobe),
    .i_nes_clock (bus.nes_clock),
    .o_data      (w_nes_data)
  );

  assign bus.pad_latch     = r_pad_latch;
  assign bus.pad_clk       = r_pad_clk;
  assign bus.buttons       = r_buttons;
  assign bus.buttons_valid = r_buttons_valid;
  assign bus.nes_data      = w_nes_data;

endmodule

// File: tb/tb_nes_joypad_poller.sv
// Directed bench for nes_joypad_poller with CLK_DIV=4, POLL_PERIOD=200 and a 4021 pad model.
module tb_nes_joypad_poller;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] pad_pressed;
  logic       alt_mode;
  logic       alt_phase = 1'b0;
  logic [7:0] pad_sr = 8'h00;

  nes_joypad_poller_if bus();

  nes_joypad_poller #(.CLK_DIV(4), .POLL_PERIOD(200)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Controller model: parallel load on latch, shift on pad_clk falling edge, active-low data.
  always @(posedge bus.pad_latch or negedge bus.pad_clk) begin
    if (bus.pad_latch) begin
      alt_phase = ~alt_phase;
      pad_sr = alt_mode ? (alt_phase ? 8'h01 : 8'h02) : pad_pressed;
    end else begin
      pad_sr = {1'b0, pad_sr[7:1]};
    end
  end
  assign bus.pad_data = ~pad_sr[0];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit found = 0;
    for (int i = 0; i < 800 && !found; i++) begin
      tick();
      if (bus.buttons_valid) found = 1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL %s: buttons_valid got=timeout want=pulse", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.nes_strobe = 1'b0;
    bus.nes_clock = 1'b0;
    pad_pressed = 8'h09;
    alt_mode = 1'b0;
    repeat (4) tick();
    total++; if (bus.pad_latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b want=0", bus.pad_latch); end
    total++; if (bus.pad_clk !== 1'b1) begin bad++; $display("FAIL reset_pad_clk got=%b want=1", bus.pad_clk); end
    total++; if (bus.buttons !== 8'h00) begin bad++; $display("FAIL reset_buttons got=%h want=00", bus.buttons); end
    total++; if (bus.buttons_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.buttons_valid); end
    total++; if (bus.nes_data !== 1'b0) begin bad++; $display("FAIL reset_nes_data got=%b want=0", bus.nes_data); end
    $display("test_reset done");
  endtask

  task automatic test_scan_timing();
    int first_latch = -1;
    int latch_hi = 0, lo_cnt = 0, falls = 0, valid_cnt = 0, valid_cyc = -1;
    logic prev_pclk = 1'b1;
    logic [7:0] after1 = 8'hxx;
    rst = 1'b0;
    for (int c = 1; c <= 470; c++) begin
      tick();
      if (bus.pad_latch && first_latch < 0) first_latch = c;
      if (bus.pad_latch && c < 300) latch_hi++;
      if (c > 200 && c < 300) begin
        if (!bus.pad_clk) lo_cnt++;
        if (prev_pclk && !bus.pad_clk) falls++;
      end
      prev_pclk = bus.pad_clk;
      if (c == 300) after1 = bus.buttons;
      if (bus.buttons_valid) begin valid_cnt++; valid_cyc = c; end
    end
    total++; if (first_latch != 200) begin bad++; $display("FAIL first_latch got=%0d want=200", first_latch); end
    total++; if (latch_hi != 4) begin bad++; $display("FAIL latch_width got=%0d want=4", latch_hi); end
    total++; if (falls != 7) begin bad++; $display("FAIL pad_clk_falls got=%0d want=7", falls); end
    total++; if (lo_cnt != 28) begin bad++; $display("FAIL pad_clk_low_clocks got=%0d want=28", lo_cnt); end
    total++; if (after1 !== 8'h00) begin bad++; $display("FAIL buttons_after_scan1 got=%h want=00", after1); end
    total++; if (bus.buttons !== 8'h09) begin bad++; $display("FAIL buttons_after_scan2 got=%h want=09", bus.buttons); end
    total++; if (valid_cnt != 1) begin bad++; $display("FAIL valid_count got=%0d want=1", valid_cnt); end
    total++; if (valid_cyc != 465) begin bad++; $display("FAIL valid_cycle got=%0d want=465", valid_cyc); end
    $display("test_scan_timing done: buttons=%h valid_cyc=%0d", bus.buttons, valid_cyc);
  endtask

  task automatic test_filter_alternating();
    int valid_cnt = 0, rises = 0;
    logic prev_latch = 1'b0;
    rst = 1'b1;
    tick(); tick();
    alt_mode = 1'b1;
    rst = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      tick();
      if (bus.buttons_valid) valid_cnt++;
      if (!prev_latch && bus.pad_latch) rises++;
      prev_latch = bus.pad_latch;
    end
    total++; if (rises != 5) begin bad++; $display("FAIL alt_scan_count got=%0d want=5", rises); end
    total++; if (valid_cnt != 0) begin bad++; $display("FAIL alt_valid got=%0d want=0", valid_cnt); end
    total++; if (bus.buttons !== 8'h00) begin bad++; $display("FAIL alt_buttons got=%h want=00", bus.buttons); end
    $display("test_filter_alternating done: buttons=%h", bus.buttons);
  endtask

  task automatic test_nes_read();
    logic [10:0] exp_seq = 11'b1111_000000_1;
    alt_mode = 1'b0;
    pad_pressed = 8'h81;
    wait_valid("read_valid");
    total++; if (bus.buttons !== 8'h81) begin bad++; $display("FAIL read_buttons got=%h want=81", bus.buttons); end
    bus.nes_strobe = 1'b1;
    tick();
    bus.nes_strobe = 1'b0;
    total++; if (bus.nes_data !== exp_seq[0]) begin bad++; $display("FAIL read_bit0 got=%b want=%b", bus.nes_data, exp_seq[0]); end
    for (int i = 1; i <= 10; i++) begin
      bus.nes_clock = 1'b1;
      tick();
      bus.nes_clock = 1'b0;
      tick();
      total++;
      if (bus.nes_data !== exp_seq[i]) begin
        bad++; $display("FAIL read_bit%0d got=%b want=%b", i, bus.nes_data, exp_seq[i]);
      end
    end
    $display("test_nes_read done");
  endtask

  task automatic test_strobe_clock_collision();
    pad_pressed = 8'h02;
    wait_valid("collide_valid");
    total++; if (bus.buttons !== 8'h02) begin bad++; $display("FAIL collide_buttons got=%h want=02", bus.buttons); end
    bus.nes_clock = 1'b1;
    tick();
    bus.nes_clock = 1'b0;
    bus.nes_strobe = 1'b1;
    tick();
    bus.nes_strobe = 1'b0;
    total++; if (bus.nes_data !== 1'b0) begin bad++; $display("FAIL collide_reload got=%b want=0", bus.nes_data); end
    bus.nes_clock = 1'b1;
    tick();
    bus.nes_clock = 1'b0;
    tick();
    total++; if (bus.nes_data !== 1'b1) begin bad++; $display("FAIL collide_bit1 got=%b want=1", bus.nes_data); end
    $display("test_strobe_clock_collision done");
  endtask

  task automatic test_enable_drop();
    bit seen = 0;
    int falls = 0, rises_off = 0, resume_k = -1;
    logic prev_pclk = 1'b1, prev_latch = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (bus.pad_latch) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL enable_find_latch got=timeout want=latch"); end
    for (int k = 1; k <= 900; k++) begin
      tick();
      if (k == 10) bus.enable = 1'b0;
      if (k == 650) bus.enable = 1'b1;
      if (k <= 100 && prev_pclk && !bus.pad_clk) falls++;
      if (k < 650 && !prev_latch && bus.pad_latch) rises_off++;
      if (k >= 650 && bus.pad_latch && resume_k < 0) resume_k = k;
      prev_pclk = bus.pad_clk;
      prev_latch = bus.pad_latch;
    end
    total++; if (falls != 7) begin bad++; $display("FAIL enable_scan_complete got=%0d want=7", falls); end
    total++; if (rises_off != 0) begin bad++; $display("FAIL enable_no_latch got=%0d want=0", rises_off); end
    total++; if (resume_k != 800) begin bad++; $display("FAIL enable_resume got=%0d want=800", resume_k); end
    $display("test_enable_drop done: resume_k=%0d", resume_k);
  endtask

  task automatic test_reset_mid_scan();
    bit seen = 0;
    int first_latch = -1;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (bus.pad_latch) seen = 1;
    end
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (!bus.pad_clk) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL midreset_find_low got=timeout want=pad_clk_low"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (bus.pad_clk !== 1'b1) begin bad++; $display("FAIL midreset_pad_clk got=%b want=1", bus.pad_clk); end
    total++; if (bus.pad_latch !== 1'b0) begin bad++; $display("FAIL midreset_latch got=%b want=0", bus.pad_latch); end
    total++; if (bus.buttons !== 8'h00) begin bad++; $display("FAIL midreset_buttons got=%h want=00", bus.buttons); end
    total++; if (bus.nes_data !== 1'b0) begin bad++; $display("FAIL midreset_nes_data got=%b want=0", bus.nes_data); end
    for (int c = 1; c <= 260; c++) begin
      tick();
      if (bus.pad_latch && first_latch < 0) first_latch = c;
    end
    total++; if (first_latch != 200) begin bad++; $display("FAIL midreset_first_latch got=%0d want=200", first_latch); end
    $display("test_reset_mid_scan done: first_latch=%0d", first_latch);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.nes_strobe = 1'b0;
    bus.nes_clock = 1'b0;
    pad_pressed = 8'h09;
    alt_mode = 1'b0;
    test_reset();
    test_scan_timing();
    test_filter_alternating();
    test_nes_read();
    test_strobe_clock_collision();
    test_enable_drop();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nes_joypad_poller.md
Name: nes_joypad_poller

Overview:
- Autonomous poller for an external NES controller (4021-style shift register) on the joypad header.
- Periodically latches the pad and shifts out 8 buttons, then filters the result over two scans.
- Serves the NES core's strobe/clock/data joypad interface from the filtered snapshot.
- Sits between the board pins and the NES core, in the system clock domain.

Parameters:
- CLK_DIV, 128: system clocks per half-period of pad_clk. Also the length of the pad_latch pulse in clocks.
- POLL_PERIOD, 357954: system clocks from one scan start to the next, about 60 Hz at 21.477 MHz. Must be greater than 20*CLK_DIV.

Ports:
- clock, in, 1: system clock, same clock as the NES core.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: when low, no new scan starts; a scan already in progress completes.
- pad_data, in, 1: serial data from the controller, active-low.
- pad_latch, out, 1: latch pulse to the controller, active-high.
- pad_clk, out, 1: shift clock to the controller; idles high.
- buttons, out, 8: filtered state, active-high. Bit order {right,left,down,up,start,select,b,a}.
- buttons_valid, out, 1: one-clock pulse when buttons updates.
- nes_strobe, in, 1: joypad strobe from the NES core.
- nes_clock, in, 1: joypad read clock from the NES core.
- nes_data, out, 1: serial bit to the NES core, active-high.

Behaviour:
- Reset values:
  - pad_latch=0, pad_clk=1, buttons=0, buttons_valid=0, nes_data=0.
  - Poll counter=0; state IDLE.
  - Internal scan shift register=0; previous-scan register=0; NES-side shift register=0.
- Poll timer: free-running counter, 0 to POLL_PERIOD-1. At wrap, a scan starts if enable=1 and the state is IDLE; otherwise that poll is skipped.
- FSM states:
  - IDLE: wait for the poll wrap.
  - LATCH: pad_latch=1 for CLK_DIV clocks, then go to SAMPLE with bit index=0.
  - SAMPLE: pad_clk=1. On the last clock of its CLK_DIV-clock phase, capture ~pad_data into scan[idx].
    - If idx=7, go to CHECK.
    - Otherwise go to SHIFT_LO.
  - SHIFT_LO: pad_clk=0 for CLK_DIV clocks, then idx+1 and go to SAMPLE.
  - CHECK: one clock, then IDLE.
- Bit capture order: idx 0=a, 1=b, 2=select, 3=start, 4=up, 5=down, 6=left, 7=right. The first bit is valid right after the latch falls, before any pad_clk falling edge.
- Filtering, evaluated in CHECK:
  - If scan==prev and scan!=buttons: set buttons<=scan and pulse buttons_valid the next clock.
  - Always set prev<=scan.
  - Consequently a change appears two scans after it first shows on the pad.
- Scan timing: from poll wrap to CHECK is 16*CLK_DIV+1 clocks (1 latch + 8 sample + 7 low phases). pad_clk produces 7 falling edges per scan.
- NES side, an emulated 4021:
  - While nes_strobe=1: shift register <= buttons every clock, and nes_data=buttons[0].
  - On a falling edge of nes_clock (registered compare, previous=1 and current=0) with nes_strobe=0: shift register <= {1'b1, sr[7:1]}.
  - nes_data = sr[0], registered. After 8 shifts the NES reads 1 continuously.
  - Strobe and a clock edge in the same cycle: the strobe load wins.
- Concurrency: an update to buttons during an NES read does not disturb the shift register; the new value is seen at the next strobe.
- enable dropped mid-scan: the scan and CHECK complete normally.
- Reset mid-scan: immediate return to reset values, with pad_clk driven high and pad_latch low the same clock.

Decomposition:
- Shared package (nes_pkg):
  - Button bit index constants BTN_A..BTN_RIGHT.
  - FSM state encoding for IDLE/LATCH/SAMPLE/SHIFT_LO/CHECK.
- One sub-module, nes_joypad_shifter: the NES-side 4021 emulation, about 40 lines. The poller holds the FSM, timers and filter.

Test Plan:
- Reset released; CLK_DIV=4, POLL_PERIOD=200; pad model holds A+start pressed (pad_data low for bits 0 and 3):
  - pad_latch is high for 4 clocks at clock 200.
  - pad_clk shows 7 low pulses of 4 clocks each.
  - After the second scan, buttons=8'h09 with one buttons_valid pulse; after the first scan, buttons=0.
- Pad pattern alternates 8'h01/8'h02 on every scan -> buttons stays 0 and buttons_valid never fires.
- buttons=8'h81 → nes_strobe pulse, then 10 nes_clock falling edges:
  - nes_data sequence is 1,0,0,0,0,0,0,1, then 1,1,1.
- nes_strobe and a nes_clock falling edge in the same clock, buttons=8'h02 → nes_data=0 the next clock (reload; the shift is ignored).
- enable deasserted 10 clocks into a scan → that scan completes; no further pad_latch pulses for 3 poll periods; scanning resumes at the first wrap after enable=1.
- reset asserted during SHIFT_LO → the next clock shows pad_clk=1, pad_latch=0, buttons=0; the first latch comes POLL_PERIOD clocks after reset release.
